// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out capture block.
// SIPO_CAPTURE_PARITY_EN appends an even-parity bit to every frame.
package sipo_pkg;

    localparam int unsigned SIPO_WIDTH_DEF = 8;

`ifdef SIPO_CAPTURE_PARITY_EN
    localparam bit SIPO_PARITY = 1'b1;
`else
    localparam bit SIPO_PARITY = 1'b0;
`endif

    typedef enum logic {EMPTY, FULL} buf_state_t;

    // Serial bits per frame: data bits plus the optional parity bit.
    function automatic int unsigned frame_bits(input int unsigned width);
        return width + (SIPO_PARITY ? 1 : 0);
    endfunction

endpackage

// File: rtl/sipo_capture_if.sv
// Serial input and word/consumer handshake bundle for sipo_capture.
interface sipo_capture_if #(
    parameter int unsigned WIDTH = sipo_pkg::SIPO_WIDTH_DEF
);
    logic             sin;
    logic             sin_valid;
    logic             msb_first;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic [WIDTH-1:0] LED;
    logic             overrun;
    logic             parity_err;

    modport master (
        output sin, sin_valid, msb_first, word_ready,
        input  word_out, word_valid, LED, overrun, parity_err
    );

    modport slave (
        input  sin, sin_valid, msb_first, word_ready,
        output word_out, word_valid, LED, overrun, parity_err
    );
endinterface

// File: rtl/sipo_bit_counter.sv
// Frame bit counter: counts accepted bits 0..FRAME-1 and wraps on the last one.
module sipo_bit_counter #(
    parameter int unsigned FRAME = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic step,
    output logic first,
    output logic last
);
    localparam int unsigned CW = $clog2(FRAME);

    logic [CW-1:0] count_q, count_d;

    assign first = (count_q == '0);
    assign last  = step && (count_q == CW'(FRAME - 1));

    always_comb begin
        count_d = count_q;
        if (last) begin
            count_d = '0;
        end else if (step) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/sipo_capture.sv
// Serial-to-parallel word capture with a one-word output buffer and overrun flag.
// Build with SIPO_CAPTURE_PARITY_EN to receive and check a trailing even-parity bit.
module sipo_capture
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           clear,
    sipo_capture_if.slave  bus
);
    localparam int unsigned FRAME = frame_bits(WIDTH);

    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             mode_q, mode_d;
    logic             ovr_q, ovr_d;
    logic             first, last;
    logic             mode_eff, take;
    logic [WIDTH-1:0] shift_val, word_new;

    sipo_bit_counter #(
        .FRAME (FRAME)
    ) u_bit_counter (
        .clk   (clk),
        .clear (clear),
        .step  (bus.sin_valid),
        .first (first),
        .last  (last)
    );

    // Bit order is latched from the first bit; later changes only affect the next frame.
    assign mode_eff  = first ? bus.msb_first : mode_q;
    assign shift_val = mode_eff ? {sr_q[WIDTH-2:0], bus.sin} : {bus.sin, sr_q[WIDTH-1:1]};
    assign take      = (state_q == FULL) && bus.word_ready;

    always_comb begin
        mode_d = mode_q;
        if (bus.sin_valid && first) begin
            mode_d = bus.msb_first;
        end
    end

`ifdef SIPO_CAPTURE_PARITY_EN
    logic perr_q, perr_d;

    // The parity bit closes the frame without entering the shift register.
    assign word_new = sr_q;
    always_comb begin
        sr_d = sr_q;
        if (bus.sin_valid && !last) begin
            sr_d = shift_val;
        end
    end
`else
    assign word_new = shift_val;
    always_comb begin
        sr_d = sr_q;
        if (bus.sin_valid) begin
            sr_d = shift_val;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        led_d   = led_q;
        ovr_d   = ovr_q;
`ifdef SIPO_CAPTURE_PARITY_EN
        perr_d  = perr_q;
`endif
        if (take) begin
            led_d   = word_q;
            state_d = EMPTY;
        end
        if (last) begin
            if (state_q == EMPTY || take) begin
                word_d  = word_new;
                state_d = FULL;
`ifdef SIPO_CAPTURE_PARITY_EN
                perr_d  = (^sr_q) ^ bus.sin;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= EMPTY;
            sr_q    <= '0;
            word_q  <= '0;
            led_q   <= '0;
            mode_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SIPO_CAPTURE_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            word_q  <= word_d;
            led_q   <= led_d;
            mode_q  <= mode_d;
            ovr_q   <= ovr_d;
`ifdef SIPO_CAPTURE_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = (state_q == FULL);
    assign bus.LED        = led_q;
    assign bus.overrun    = ovr_q;
`ifdef SIPO_CAPTURE_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: doc/sipo_capture.md
SIPO_CAPTURE -- requirements
Module: sipo_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data word width in bits; legal values are 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clear, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 SHALL have port sin, input, 1 bit: serial data bit.
REQ-005 SHALL have port sin_valid, input, 1 bit: sin is sampled on each clk edge where sin_valid=1.
REQ-006 SHALL have port msb_first, input, 1 bit: 1 = first bit lands in the MSB, 0 = first bit lands in the LSB.
REQ-007 SHALL have port word_out, output, WIDTH bits: the completed word held for the consumer.
REQ-008 SHALL have port word_valid, output, 1 bit: word_out holds an unconsumed word.
REQ-009 SHALL have port word_ready, input, 1 bit: consumer accept; a transfer occurs on an edge where word_valid=1 and word_ready=1.
REQ-010 SHALL have port LED, output, WIDTH bits: the last word transferred to the consumer.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag indicating a completed word was dropped.
REQ-012 SHALL have port parity_err, output, 1 bit: parity mismatch on the word currently held in word_out.

Function
REQ-013 SHALL shift one bit per sin_valid edge: for msb_first=1, sr <= {sr[WIDTH-2:0], sin}; for msb_first=0, sr <= {sin, sr[WIDTH-1:1]}.
REQ-014 SHALL sample msb_first on the first bit of a frame (bit count 0) and hold that value for the rest of the frame; mid-frame changes SHALL be ignored.
REQ-015 SHALL count bits 0..FRAME-1, where FRAME = WIDTH (or WIDTH+1 when parity is enabled), and wrap the count to 0 on the last bit.
REQ-016 SHALL run an output buffer state machine with two states:
- EMPTY: word_valid=0.
- FULL: word_valid=1.
REQ-017 On the last data bit, if the buffer is EMPTY, or FULL and being consumed on the same edge, SHALL load word_out with the completed word and go to (or stay in) FULL.
- word_valid rises on the edge that samples the last bit, so it is visible in the following cycle (1-cycle latency).
REQ-018 On the last data bit, if the buffer is FULL and word_ready=0, SHALL drop the new word, leave word_out unchanged, set overrun=1, and restart the bit count at 0.
REQ-019 On a transfer edge with no word completing, SHALL go FULL->EMPTY and load LED <= word_out.
REQ-020 SHALL hold word_out stable while word_valid=1 and word_ready=0.
REQ-021 SHALL clear overrun only by clear.
REQ-022 Edges with sin_valid=0 SHALL leave the shift register and bit count unchanged; gaps between bits are unbounded.

Reset
REQ-023 With clear=1 at a clk edge, SHALL set word_out=0, word_valid=0, LED=0, overrun=0, parity_err=0, bit count=0, shift register=0, and state=EMPTY.
REQ-024 Reset SHALL take priority over every other input in the same cycle.
- A partial frame or held word SHALL be discarded, with no transfer to LED.

Configuration
REQ-025 SHALL use macro SIPO_CAPTURE_PARITY_EN to select parity handling.
REQ-026 With SIPO_CAPTURE_PARITY_EN defined:
- FRAME = WIDTH+1; the final bit is an even-parity bit over the data bits and is not stored in word_out.
- parity_err SHALL be loaded together with word_out, set to 1 when the XOR of the data bits and the parity bit is 1.
- A word with a parity error SHALL still be delivered normally.
REQ-027 Without SIPO_CAPTURE_PARITY_EN:
- FRAME = WIDTH.
- parity_err SHALL be tied to 0; the port SHALL still exist.

Structure
REQ-028 Package sipo_pkg SHALL hold:
- constant SIPO_WIDTH_DEF = 8;
- typedef enum buf_state_t {EMPTY, FULL}.
REQ-029 The bit counter (count, wrap, last-bit strobe) SHALL be a sub-module, sipo_bit_counter, parameterised by FRAME.

Verification
REQ-030 MSB-first: send WIDTH=8 bits 1,0,1,1,0,0,1,0 with word_ready=1 -> word_out=8'hB2 and word_valid=1 the cycle after the 8th bit, then LED=8'hB2 after the accept.
REQ-031 LSB-first: send the same bit sequence with msb_first=0 -> word_out=8'h4D.
REQ-032 Backpressure: hold word_ready=0 and send two full frames 8'hA5 then 8'h3C -> word_out stays 8'hA5 and overrun=1 after the 16th bit; raise word_ready -> LED=8'hA5, then word_valid=0.
REQ-033 Reset mid-frame: assert clear after 5 bits, then send frame 8'h0F -> word_out=8'h0F with no corruption, and overrun=0.
REQ-034 Simultaneous accept and complete: while FULL with 8'h11, the 8th bit of 8'h22 coincides with word_ready=1 -> LED=8'h11, word_out=8'h22, word_valid stays 1, overrun=0.
REQ-035 Parity (macro defined): send 8'h03 with parity bit 1 -> parity_err=1; send 8'h03 with parity bit 0 -> parity_err=0.
